tlc_multi_phase: RTL

Parametrised N-direction traffic-light phase controller, successor to the fixed 4-way TrafficLight core. Rotates a green/yellow/all-red sequence across N_DIR approaches with per-direction demand masking and latched pedestrian service. Its packed nibble status bus has the same 1/2/4 encoding used by the existing light-status checkers, so current benches can compare it directly. Timing is derived from a tick-enable input, not from raw clocks.

---
 rtl/tlc_pkg.sv | 10 +
 rtl/tlc_next_dir.sv | 25 ++
 rtl/tlc_multi_phase.sv | 113 +++++++++++
 3 files changed

// File: rtl/tlc_pkg.sv
// tlc_pkg: phase encoding plus per-direction light and status constants.
package tlc_pkg;
    typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, ALLRED = 2'd2, PED = 2'd3} phase_t;
    localparam logic [2:0] LT_GREEN  = 3'b001;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_RED    = 3'b100;
    localparam logic [3:0] ST_GREEN  = 4'h1;
    localparam logic [3:0] ST_YELLOW = 4'h2;
    localparam logic [3:0] ST_RED    = 4'h4;
endpackage

// File: rtl/tlc_next_dir.sv
// tlc_next_dir: rotating priority search for the next enabled direction after cur_dir.
module tlc_next_dir #(
    parameter int N_DIR = 4
) (
    input  logic [N_DIR-1:0] dir_en,
    input  logic [2:0]       cur_dir,
    output logic [2:0]       nxt_dir,
    output logic             valid
);
    logic [2*N_DIR-1:0] w_dbl;
    logic [N_DIR-1:0]   w_rot;
    logic [3:0]         w_off;
    logic [3:0]         w_sum;
    // bit i of w_rot is direction (cur_dir+1+i) mod N_DIR, so the lowest set bit wins
    assign w_dbl = {dir_en, dir_en} >> ({1'b0, cur_dir} + 4'd1);
    assign w_rot = w_dbl[N_DIR-1:0];
    always_comb begin
        w_off = '0;
        for (int i = N_DIR - 1; i >= 0; i--)
            if (w_rot[i]) w_off = 4'(i);
    end
    assign w_sum   = {1'b0, cur_dir} + 4'd1 + w_off;
    assign nxt_dir = 3'(w_sum >= 4'(N_DIR) ? w_sum - 4'(N_DIR) : w_sum);
    assign valid   = |dir_en;
endmodule

// File: rtl/tlc_multi_phase.sv
// tlc_multi_phase: N-direction green/yellow/all-red rotation with demand mask and latched pedestrian phase.
module tlc_multi_phase
    import tlc_pkg::*;
#(
    parameter int N_DIR    = 4,
    parameter int GREEN_T  = 8,
    parameter int YELLOW_T = 2,
    parameter int ALLRED_T = 1,
    parameter int PED_T    = 6,
    parameter int TW       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               ped_req,
    input  logic [N_DIR-1:0]   dir_en,
    output logic [3*N_DIR-1:0] lights,
    output logic [4*N_DIR-1:0] status,
    output logic [2:0]         cur_dir,
    output logic [1:0]         phase,
    output logic               ped_walk,
    output logic               ped_pending
);
    localparam logic [TW-1:0] L_GREEN  = TW'(GREEN_T - 1);
    localparam logic [TW-1:0] L_YELLOW = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] L_ALLRED = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] L_PED    = TW'(PED_T - 1);
    localparam logic [2:0]    LAST_DIR = 3'(N_DIR - 1);

    phase_t        r_phase, w_phase_n;
    logic [2:0]    r_dir, w_dir_n, w_nxt;
    logic [TW-1:0] r_timer, w_timer_n;
    logic          r_ped, w_enter_ped, w_valid, w_bad;

    tlc_next_dir #(.N_DIR(N_DIR)) u_next (
        .dir_en  (dir_en),
        .cur_dir (r_dir),
        .nxt_dir (w_nxt),
        .valid   (w_valid)
    );

    assign w_bad = {1'b0, r_dir} >= 4'(N_DIR);

    always_comb begin
        w_phase_n   = r_phase;
        w_dir_n     = r_dir;
        w_timer_n   = r_timer;
        w_enter_ped = 1'b0;
        if (w_bad) begin
            w_phase_n = ALLRED;
            w_dir_n   = LAST_DIR;
            w_timer_n = L_ALLRED;
        end else if (en && r_timer != '0) begin
            w_timer_n = r_timer - TW'(1);
        end else if (en) begin
            case (r_phase)
                GREEN: begin
                    w_phase_n = YELLOW;
                    w_timer_n = L_YELLOW;
                end
                YELLOW: begin
                    w_phase_n = ALLRED;
                    w_timer_n = L_ALLRED;
                end
                ALLRED: begin
                    w_timer_n = r_ped ? L_PED : w_valid ? L_GREEN : L_ALLRED;
                    w_phase_n = r_ped ? PED : w_valid ? GREEN : ALLRED;
                    w_dir_n   = !r_ped && w_valid ? w_nxt : r_dir;
                    w_enter_ped = r_ped;
                end
                PED: begin
                    w_timer_n = w_valid ? L_GREEN : L_ALLRED;
                    w_phase_n = w_valid ? GREEN : ALLRED;
                    w_dir_n   = w_valid ? w_nxt : r_dir;
                end
                default: begin
                    w_phase_n = ALLRED;
                    w_dir_n   = LAST_DIR;
                    w_timer_n = L_ALLRED;
                end
            endcase
        end
    end

    // a request on the PED entry edge outranks the clear, so it is served next ALLRED
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= ALLRED;
            r_dir   <= LAST_DIR;
            r_timer <= L_ALLRED;
            r_ped   <= 1'b0;
        end else begin
            r_phase <= w_phase_n;
            r_dir   <= w_dir_n;
            r_timer <= w_timer_n;
            r_ped   <= ped_req | (r_ped & ~w_enter_ped);
        end
    end

    for (genvar d = 0; d < N_DIR; d++) begin : g_dir
        logic w_own;
        assign w_own = r_dir == 3'(d);
        assign lights[3*d +: 3] = w_own && r_phase == GREEN  ? LT_GREEN  :
                                  w_own && r_phase == YELLOW ? LT_YELLOW : LT_RED;
        assign status[4*d +: 4] = w_own && r_phase == GREEN  ? ST_GREEN  :
                                  w_own && r_phase == YELLOW ? ST_YELLOW : ST_RED;
    end

    assign cur_dir     = r_dir;
    assign phase       = r_phase;
    assign ped_walk    = r_phase == PED;
    assign ped_pending = r_ped;
endmodule
